// File: rtl/trig_capture.sv
// trig_capture: level-crossing trigger with circular pre/post capture buffer for the scope datapath
// Optional build macro AUTO_TRIG_EN: force a trigger after TIMEOUT untriggered samples in WAIT.
module trig_capture #(
    parameter int SAMPLE_W = 12,
    parameter int DEPTH    = 640,
    parameter int ADDR_W   = 10,
    parameter int PRETRIG  = 64,
    parameter int TIMEOUT  = 65535
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] trig_level,
    input  logic                rising,
    input  logic                arm,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [SAMPLE_W-1:0] rd_data,
    output logic                full,
    output logic                triggered,
    output logic                auto_trig
);
    localparam int POSTN = DEPTH - PRETRIG - 1;
    localparam int MW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_wptr;
    logic [ADDR_W-1:0]   r_tptr;
    logic [CNT_W-1:0]    r_cnt;
    logic [SAMPLE_W-1:0] r_prev;
    logic [SAMPLE_W-1:0] r_lvl;
    logic                r_prev_vld;
    logic                r_rise;
    logic                r_full;
    logic                r_trig;
    logic                r_auto;
    logic [SAMPLE_W-1:0] r_mem [DEPTH];
    logic [SAMPLE_W-1:0] r_q;
    logic                r_zero;

    logic                w_cap;
    logic                w_acc;
    logic                w_cross;
    logic                w_force;
    logic                w_fire;
    logic                w_oob;
    logic [ADDR_W-1:0]   w_wnext;
    logic [ADDR_W-1:0]   w_start;
    logic [ADDR_W:0]     w_sum;
    logic [ADDR_W-1:0]   w_phys;
    logic [ADDR_W-1:0]   w_raddr;

    assign w_cap   = (r_state == S_PRE) || (r_state == S_WAIT) || (r_state == S_POST);
    assign w_acc   = sample_valid && !arm && w_cap;
    assign w_cross = r_prev_vld && (r_rise ? (r_prev < r_lvl && sample_in >= r_lvl)
                                           : (r_prev > r_lvl && sample_in <= r_lvl));
    assign w_fire  = (r_state == S_WAIT) && w_acc && (w_cross || w_force);
    assign w_wnext = (r_wptr == LAST) ? '0 : r_wptr + 1'b1;

`ifdef AUTO_TRIG_EN
    localparam int TO_W = $clog2(TIMEOUT + 2);
    logic [TO_W-1:0] r_to;
    assign w_force = (r_to == TO_W'(TIMEOUT));
    // count untriggered WAIT samples; held at zero outside WAIT so it restarts on every entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_to <= '0;
        else if (arm || r_state != S_WAIT) r_to <= '0;
        else if (w_acc && !w_fire) r_to <= r_to + 1'b1;
    end
`else
    assign w_force = 1'b0;
`endif

    // capture sequencer: arm restarts, accepted samples advance PRE -> WAIT -> POST -> DONE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_wptr     <= '0;
            r_tptr     <= '0;
            r_cnt      <= '0;
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
            r_lvl      <= '0;
            r_rise     <= 1'b0;
            r_full     <= 1'b0;
            r_trig     <= 1'b0;
            r_auto     <= 1'b0;
        end else if (arm) begin
            r_state    <= S_PRE;
            r_cnt      <= '0;
            r_prev_vld <= 1'b0;
            r_lvl      <= trig_level;
            r_rise     <= rising;
            r_full     <= 1'b0;
            r_trig     <= 1'b0;
            r_auto     <= 1'b0;
        end else if (w_acc) begin
            r_wptr     <= w_wnext;
            r_prev     <= sample_in;
            r_prev_vld <= 1'b1;
            case (r_state)
                S_PRE: begin
                    if (r_cnt == CNT_W'(PRETRIG - 1)) begin
                        r_state <= S_WAIT;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (w_fire) begin
                        r_tptr <= r_wptr;
                        r_trig <= 1'b1;
                        r_auto <= !w_cross;
                        if (POSTN == 0) begin
                            r_state <= S_DONE;
                            r_full  <= 1'b1;
                        end else begin
                            r_state <= S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (r_cnt == CNT_W'(POSTN - 1)) begin
                        r_state <= S_DONE;
                        r_full  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // write port: one sample per accepted strobe at the running write pointer
    always_ff @(posedge clk) begin
        if (w_acc) r_mem[r_wptr[MW-1:0]] <= sample_in;
    end

    // oldest pre-trigger sample sits PRETRIG slots behind the trigger, wrapped into [0, DEPTH)
    assign w_start = (r_tptr >= ADDR_W'(PRETRIG)) ? r_tptr - ADDR_W'(PRETRIG)
                                                  : r_tptr + ADDR_W'(DEPTH - PRETRIG);
    assign w_sum   = {1'b0, w_start} + {1'b0, rd_addr};
    assign w_phys  = (w_sum >= (ADDR_W+1)'(DEPTH)) ? ADDR_W'(w_sum - (ADDR_W+1)'(DEPTH))
                                                   : w_sum[ADDR_W-1:0];
    assign w_oob   = {1'b0, rd_addr} >= (ADDR_W+1)'(DEPTH);
    assign w_raddr = w_oob ? '0 : w_phys;

    // read port kept reset-free so it maps onto block RAM
    always_ff @(posedge clk) begin
        r_q <= r_mem[w_raddr[MW-1:0]];
    end

    // zero mask for out-of-range addresses and for the output straight after reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_zero <= 1'b1;
        else r_zero <= w_oob;
    end

    assign rd_data   = r_zero ? '0 : r_q;
    assign full      = r_full;
    assign triggered = r_trig;
    assign auto_trig = r_auto;
endmodule

// File: tb/tb_trig_capture.sv
// tb_trig_capture: randomized and directed checks of trig_capture against a sample-list model
module tb_trig_capture;
    localparam int D  = 16;
    localparam int P  = 4;
    localparam int PN = D - P - 1;
    localparam int TO = 8;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [11:0]   sample_in;
    logic          sample_valid;
    logic [11:0]   trig_level;
    logic          rising;
    logic          arm;
    logic [AW-1:0] rd_addr;
    logic [11:0]   rd_data;
    logic          full;
    logic          triggered;
    logic          auto_trig;

    int            vec = 0;
    int            errs = 0;

    bit            m_active = 0;
    logic [11:0]   m_lvl;
    bit            m_rise;
    logic [11:0]   q[$];

    trig_capture #(.SAMPLE_W(12), .DEPTH(D), .ADDR_W(AW), .PRETRIG(P), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .sample_in(sample_in), .sample_valid(sample_valid),
        .trig_level(trig_level), .rising(rising), .arm(arm), .rd_addr(rd_addr),
        .rd_data(rd_data), .full(full), .triggered(triggered), .auto_trig(auto_trig)
    );

    always #5 clk = ~clk;

    function automatic int find_trig(output bit au);
        au = 0;
        for (int i = P; i < q.size(); i++) begin
            if (m_rise ? (q[i-1] < m_lvl && q[i] >= m_lvl) : (q[i-1] > m_lvl && q[i] <= m_lvl))
                return i;
`ifdef AUTO_TRIG_EN
            if (i - P == TO) begin
                au = 1;
                return i;
            end
`endif
        end
        return -1;
    endfunction

    function automatic bit m_done();
        bit au;
        int t;
        t = find_trig(au);
        return t >= 0 && q.size() > t + PN;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vec++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_flags(input string tag);
        bit au;
        int t;
        t = find_trig(au);
        chk({tag, " full"}, full, m_done());
        chk({tag, " triggered"}, triggered, t >= 0);
        chk({tag, " auto_trig"}, auto_trig, t >= 0 && au);
    endtask

    task automatic start_model(input logic [11:0] lvl, input bit rise);
        m_active = 1;
        m_lvl = lvl;
        m_rise = rise;
        q.delete();
    endtask

    task automatic do_arm(input logic [11:0] lvl, input bit rise);
        @(negedge clk);
        trig_level = lvl;
        rising = rise;
        arm = 1;
        @(negedge clk);
        arm = 0;
        trig_level = 12'($urandom);
        rising = 1'($urandom);
        start_model(lvl, rise);
        check_flags("arm");
    endtask

    task automatic send(input logic [11:0] v);
        @(negedge clk);
        sample_in = v;
        sample_valid = 1;
        @(negedge clk);
        sample_valid = 0;
        if (m_active && !m_done()) q.push_back(v);
        check_flags("sample");
    endtask

    task automatic rd(input int a, output logic [11:0] d);
        @(negedge clk);
        rd_addr = AW'(a);
        @(negedge clk);
        d = rd_data;
    endtask

    task automatic read_all(input string tag);
        bit au;
        int t;
        logic [11:0] d;
        t = find_trig(au);
        for (int a = 0; a < 2 * D; a++) begin
            rd(a, d);
            chk($sformatf("%s rd[%0d]", tag, a), d, a < D ? q[t - P + a] : 12'h000);
        end
    endtask

    initial begin
        logic [11:0] d;
        reset_n = 0; sample_in = 0; sample_valid = 0; trig_level = 0; rising = 0; arm = 0; rd_addr = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset full", full, 0);
        chk("reset triggered", triggered, 0);
        chk("reset auto_trig", auto_trig, 0);
        chk("reset rd_data", rd_data, 0);
        reset_n = 1;

        do_arm(12'h800, 1);
        for (int k = 0; k < 28; k++) send(12'(12'h080 * k));
        read_all("rise");
        rd(0, d);  chk("rise addr0", d, 12'h600);
        rd(4, d);  chk("rise addr4", d, 12'h800);
        rd(15, d); chk("rise addr15", d, 12'hD80);
        rd(16, d); chk("rise addr16", d, 12'h000);

        do_arm(12'h400, 0);
        for (int k = 0; k < 34; k++) send(12'(12'hF00 - 12'h080 * k));
        read_all("fall");
        rd(4, d); chk("fall addr4", d, 12'h400);
        rd(3, d); chk("fall addr3", d, 12'h480);

        do_arm(12'h800, 1);
        for (int k = 0; k < 100; k++) send(12'h800);

        do_arm(12'h800, 1);
        for (int k = 0; k < 20; k++) send(12'(12'h080 * k));
        do_arm(12'h800, 1);
        for (int k = 0; k < 28; k++) send(12'(12'h080 * k));
        read_all("rearm");

        @(negedge clk);
        trig_level = 12'h800; rising = 1; arm = 1; sample_valid = 1; sample_in = 12'hABC;
        @(negedge clk);
        arm = 0; sample_valid = 0;
        start_model(12'h800, 1);
        check_flags("arm+valid");
        send(12'h000); send(12'h100); send(12'h200); send(12'h300); send(12'h900);
        for (int k = 0; k < PN; k++) send(12'(12'h910 + k));
        read_all("armvalid");
        rd(0, d); chk("no 0xABC at addr0", d != 12'hABC, 1);

        do_arm(12'h800, 1);
        for (int k = 0; k < 20; k++) send(12'(12'h080 * k));
        @(negedge clk);
        reset_n = 0;
        #1;
        m_active = 0;
        q.delete();
        chk("midpost rst full", full, 0);
        chk("midpost rst triggered", triggered, 0);
        chk("midpost rst auto_trig", auto_trig, 0);
        chk("midpost rst rd_data", rd_data, 0);
        #3 reset_n = 1;
        for (int k = 0; k < 10; k++) send(12'(12'h100 * k));

`ifdef AUTO_TRIG_EN
        do_arm(12'h800, 1);
        for (int k = 0; k < 30; k++) send(12'h100);
        chk("auto flag", auto_trig, 1);
        read_all("auto");
`endif

        for (int c = 0; c < 8; c++) begin
            do_arm(12'($urandom_range(0, 4095)), 1'($urandom));
            for (int k = 0; k < 200 && !m_done(); k++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                if ($urandom_range(0, 149) == 0) do_arm(12'($urandom), 1'($urandom));
                send(12'($urandom));
            end
            if (m_done()) read_all("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
